fix_ari_acc: RTL and testbench
==============================

# fix_ari_acc

Sign-magnitude fixed-point accumulator that sits directly downstream of the fixed-point multiplier stage. It consumes the multiplier's rounded Q7.8 products over a valid/ready stream and sums each group of beats terminated by `in_last`. At the end of each group it emits one saturated Q7.8 result, also in sign-magnitude, for use by dot-product and filter datapaths.

## Interface
- `DATA`, 16, word width; bit `DATA-1` is the sign, the remaining bits are the magnitude.
- `INTE`, 7, integer magnitude bits.
- `POIN`, 8, fractional bits (`INTE+POIN == DATA-1`).
- `LEN_W`, 8, beat-counter width; a group holds at most 2^`LEN_W`-1 beats.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  `DATA`  sign-magnitude Q7.8 product.
- `in_valid`  in  1  `in_data` / `in_last` are valid.
- `in_last`  in  1  the current beat closes the group.
- `in_ready`  out  1  the block accepts a beat this cycle.
- `out_data`  out  `DATA`  sign-magnitude Q7.8 group sum.
- `out_sat`  out  1  the group sum was clipped.
- `out_count`  out  `LEN_W`  number of beats in the group.
- `out_valid`  out  1  the result fields are valid.
- `out_ready`  in  1  the consumer takes the result.

## Operation
- FSM states and transitions:
  - `ACC`: `in_ready`=1, `out_valid`=0. This is the reset state.
  - `OUT`: `in_ready`=0, `out_valid`=1.
  - `ACC`→`OUT` on an accepted beat that is last.
  - `OUT`→`ACC` on `out_valid & out_ready`.
- A beat is accepted when `in_valid & in_ready`. Each accepted beat is converted from sign-magnitude to two's complement and added into `acc`.
  - `acc` is a signed register of `DATA+LEN_W` bits. It cannot overflow.
  - Negative zero (0x8000) converts to 0.
- Beat counter `cnt` (`LEN_W` bits) increments on every accepted beat.
- A beat is "last" if `in_last`=1, or if `cnt` == 2^`LEN_W`-2 before the beat, which forces the group closed at the maximum length.
- On the edge that accepts a last beat:
  - Compute `acc + beat` and saturate it to magnitude ≤ 2^(`DATA-1`)-1.
  - Register the result in sign-magnitude into `out_data`, set `out_sat` if clipped, set `out_count` = `cnt`+1.
  - Clear `acc` and `cnt` to 0.
- Output format: zero always carries sign 0. A clipped result keeps the sign of the true sum.
- `out_data`, `out_sat` and `out_count` hold stable while `out_valid & !out_ready`.
- No bypass: the block accepts no input while in `OUT`.

## Timing
- Reset values (asynchronous): state `ACC`, `acc`=0, `cnt`=0, `out_data`=0, `out_sat`=0, `out_count`=0, `out_valid`=0.
- `in_ready` is decoded from the state, so it is 1 immediately after reset.
- Latency: `out_valid` rises in the first cycle after the edge that accepts the last beat.
- Throughput:
  - An `N`-beat group takes `N`+1 cycles when `out_ready` is held high.
  - The cycle with `out_valid`=1 always has `in_ready`=0.
  - After the handshake edge, `in_ready`=1 in the next cycle.
- A single-beat group (`in_last` on the first beat) is legal.
  - `out_count`=1.
  - `out_data` = that beat, normalised (negative zero becomes 0).
- `in_valid`=0 gaps inside a group are allowed and change nothing.
- An assertion of `rst_n` mid-group or mid-`OUT` discards all partial state; no output is produced for that group.

## Structure
- The package `fix_ari_pkg` holds:
  - the constants `DATA`, `INTE`, `POIN`, shared with the multiplier;
  - the sign-magnitude↔two's-complement conversion functions;
  - the constant `SM_MAX` = 2^(`DATA-1`)-1.
- One sub-module, `fix_ari_sat`, is combinational. It takes the wide signed sum and produces the sign-magnitude word plus the `sat` flag. The accumulator FSM instantiates it once on the `acc + beat` path.

## Test plan
- Sum and count:
  - Stimulus: beats 0x0100, 0x0200, then 0x8080 with `in_last`.
  - Response: `out_data`=0x0280, `out_sat`=0, `out_count`=3, `out_valid` one cycle after the last beat.
- Saturation:
  - Stimulus: 0x7FFF, then 0x0001 (last).
  - Response: 0x7FFF, `out_sat`=1.
  - Stimulus: 0xFFFF, then 0x8001 (last).
  - Response: 0xFFFF, `out_sat`=1.
- Zero normalisation:
  - Stimulus: 0x8000 (last).
  - Response: 0x0000, `out_count`=1.
  - Stimulus: 0x0100, then 0x8100 (last).
  - Response: 0x0000, sign 0.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles in `OUT` while driving `in_valid`=1.
  - Response: `in_ready`=0, `out_*` stable, no beat absorbed; the next group starts correctly after the handshake.
- Forced close:
  - Stimulus: 255 beats of 0x0001 with `in_last`=0.
  - Response: `out_data`=0x00FF, `out_count`=255, `out_sat`=0. The 256th beat starts a new group.
- Reset mid-group:
  - Stimulus: 2 beats, pulse `rst_n` low, then 0x0100 (last).
  - Response: all outputs 0 during reset; result 0x0100 with `out_count`=1.

Source files
------------

// File: rtl/fix_ari_pkg.sv
// fix_ari_pkg: Q7.8 format constants, FSM state type and sign-magnitude conversions
// Revision 1.0
`default_nettype none

package fix_ari_pkg;

   localparam int DATA = 16;
   localparam int INTE = 7;
   localparam int POIN = 8;

   localparam logic [DATA-1:0] SM_MAX = DATA'((1 << (DATA-1)) - 1);

   typedef enum logic [0:0] {
      ST_ACC = 1'b0,
      ST_OUT = 1'b1
   } acc_state_t;

   // Negative zero maps onto plain zero because -0 == 0 in two's complement.
   function automatic logic signed [DATA-1:0] sm2tc(input logic [DATA-1:0] sm);
      logic signed [DATA-1:0] mag;
      mag = $signed({1'b0, sm[DATA-2:0]});
      return sm[DATA-1] ? -mag : mag;
   endfunction

   // The caller guarantees |v| <= SM_MAX, so the most negative code never occurs.
   function automatic logic [DATA-1:0] tc2sm(input logic signed [DATA-1:0] v);
      logic [DATA-1:0] mag;
      mag = v[DATA-1] ? DATA'(-v) : DATA'(v);
      return {v[DATA-1], mag[DATA-2:0]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/fix_ari_sat.sv
// fix_ari_sat: clip a wide two's-complement sum to the Q7.8 sign-magnitude range
// Revision 1.0
`default_nettype none

module fix_ari_sat
   import fix_ari_pkg::*;
#(
   parameter int W = 24
) (
   input  logic signed [W-1:0]    sum,
   output logic        [DATA-1:0] sm,
   output logic                   sat
);

   localparam logic signed [W-1:0]    HI_W = W'(SM_MAX);
   localparam logic signed [W-1:0]    LO_W = -HI_W;
   localparam logic signed [DATA-1:0] HI_D = $signed(SM_MAX);

   logic                   over_hi;
   logic                   over_lo;
   logic signed [DATA-1:0] clipped;

   always_comb begin
      over_hi = (sum > HI_W);
      over_lo = (sum < LO_W);
      sat     = over_hi | over_lo;
      // A clipped result keeps the sign of the true sum.
      if (over_hi) begin
         clipped = HI_D;
      end else if (over_lo) begin
         clipped = -HI_D;
      end else begin
         clipped = sum[DATA-1:0];
      end
      sm = tc2sm(clipped);
   end

endmodule

`default_nettype wire

// File: rtl/fix_ari_acc.sv
// fix_ari_acc: groups Q7.8 sign-magnitude beats, emits one saturated sum per group
// Revision 1.0
`default_nettype none

module fix_ari_acc
   import fix_ari_pkg::*;
#(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DATA-1:0]  in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [DATA-1:0]  out_data,
   output logic             out_sat,
   output logic [LEN_W-1:0] out_count,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int ACC_W = DATA + LEN_W;
   localparam logic [LEN_W-1:0] CNT_LAST = LEN_W'((1 << LEN_W) - 2);

   acc_state_t              state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [LEN_W-1:0]        cnt_q, cnt_d;
   logic [DATA-1:0]         out_data_q, out_data_d;
   logic                    out_sat_q, out_sat_d;
   logic [LEN_W-1:0]        out_count_q, out_count_d;

   logic signed [DATA-1:0]  beat;
   logic signed [ACC_W-1:0] sum;
   logic [DATA-1:0]         sum_sm;
   logic                    sum_sat;
   logic                    accept;
   logic                    last;

   fix_ari_sat #(.W(ACC_W)) u_sat (
      .sum (sum),
      .sm  (sum_sm),
      .sat (sum_sat)
   );

   always_comb begin
      beat   = sm2tc(in_data);
      sum    = acc_q + {{LEN_W{beat[DATA-1]}}, beat};
      accept = in_valid & (state_q == ST_ACC);
      // Reaching the maximum length closes the group even without in_last.
      last   = in_last | (cnt_q == CNT_LAST);

      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      out_count_d = out_count_q;

      if (accept) begin
         if (last) begin
            state_d     = ST_OUT;
            acc_d       = '0;
            cnt_d       = '0;
            out_data_d  = sum_sm;
            out_sat_d   = sum_sat;
            out_count_d = cnt_q + LEN_W'(1);
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + LEN_W'(1);
         end
      end else if ((state_q == ST_OUT) && out_ready) begin
         state_d = ST_ACC;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ACC;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         out_count_q <= out_count_d;
      end
   end

   assign in_ready  = (state_q == ST_ACC);
   assign out_valid = (state_q == ST_OUT);
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign out_count = out_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fix_ari_acc.sv
// tb_fix_ari_acc: directed self-checking bench for fix_ari_acc
// Revision 1.0
`default_nettype none

module tb_fix_ari_acc;

   logic        clk;
   logic        rst_n;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_sat;
   logic [7:0]  out_count;
   logic        out_valid;
   logic        out_ready;

   int checks;
   int errors;

   fix_ari_acc #(.LEN_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .out_count (out_count),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one beat from posedge+1 and returns at posedge+1 after it is taken.
   task automatic send_beat(input logic [15:0] d, input logic l);
      int n;
      in_data  = d;
      in_last  = l;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL send_beat_timeout: in_ready=%0b required 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_sat !== 1'b0 || out_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%0b data=%h sat=%0b count=%0d required 0 0000 0 0",
                  out_valid, out_data, out_sat, out_count);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_sum_count;
      send_beat(16'h0100, 1'b0);
      send_beat(16'h0200, 1'b0);
      send_beat(16'h8080, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0280 || out_sat !== 1'b0 || out_count !== 8'd3) begin
         errors++;
         $display("FAIL sum_count: valid=%0b data=%h sat=%0b count=%0d required 1 0280 0 3",
                  out_valid, out_data, out_sat, out_count);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL sum_in_ready: got %0b required 0", in_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL sum_release: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_saturation;
      send_beat(16'h7FFF, 1'b0);
      send_beat(16'h0001, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h7FFF || out_sat !== 1'b1 || out_count !== 8'd2) begin
         errors++;
         $display("FAIL sat_pos: valid=%0b data=%h sat=%0b count=%0d required 1 7fff 1 2",
                  out_valid, out_data, out_sat, out_count);
      end
      @(posedge clk);
      #1;
      send_beat(16'hFFFF, 1'b0);
      send_beat(16'h8001, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'hFFFF || out_sat !== 1'b1 || out_count !== 8'd2) begin
         errors++;
         $display("FAIL sat_neg: valid=%0b data=%h sat=%0b count=%0d required 1 ffff 1 2",
                  out_valid, out_data, out_sat, out_count);
      end
      @(posedge clk);
      #1;
      // Large but in-range negative sum must not be flagged.
      send_beat(16'hC000, 1'b0);
      send_beat(16'h8FFF, 1'b1);
      checks++;
      if (out_data !== 16'hCFFF || out_sat !== 1'b0) begin
         errors++;
         $display("FAIL sat_edge: data=%h sat=%0b required cfff 0", out_data, out_sat);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_zero_norm;
      send_beat(16'h8000, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_sat !== 1'b0 || out_count !== 8'd1) begin
         errors++;
         $display("FAIL neg_zero: valid=%0b data=%h sat=%0b count=%0d required 1 0000 0 1",
                  out_valid, out_data, out_sat, out_count);
      end
      @(posedge clk);
      #1;
      send_beat(16'h0100, 1'b0);
      send_beat(16'h8100, 1'b1);
      checks++;
      if (out_data !== 16'h0000 || out_count !== 8'd2) begin
         errors++;
         $display("FAIL cancel_zero: data=%h count=%0d required 0000 2", out_data, out_count);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      send_beat(16'h0010, 1'b0);
      send_beat(16'h0020, 1'b1);
      in_data  = 16'h0700;
      in_last  = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h0030 || out_count !== 8'd2 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold[%0d]: in_ready=%0b valid=%0b data=%h count=%0d sat=%0b required 0 1 0030 2 0",
                     i, in_ready, out_valid, out_data, out_count, out_sat);
         end
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_release: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
      end
      send_beat(16'h0005, 1'b1);
      checks++;
      if (out_data !== 16'h0005 || out_count !== 8'd1) begin
         errors++;
         $display("FAIL backpressure_next: data=%h count=%0d required 0005 1", out_data, out_count);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_forced_close;
      for (int i = 0; i < 255; i++) begin
         send_beat(16'h0001, 1'b0);
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h00FF || out_sat !== 1'b0 || out_count !== 8'd255) begin
         errors++;
         $display("FAIL forced_close: valid=%0b data=%h sat=%0b count=%0d required 1 00ff 0 255",
                  out_valid, out_data, out_sat, out_count);
      end
      @(posedge clk);
      #1;
      send_beat(16'h0003, 1'b1);
      checks++;
      if (out_data !== 16'h0003 || out_count !== 8'd1) begin
         errors++;
         $display("FAIL forced_next: data=%h count=%0d required 0003 1", out_data, out_count);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_group;
      send_beat(16'h0100, 1'b0);
      send_beat(16'h0100, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_sat !== 1'b0 || out_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs: valid=%0b data=%h sat=%0b count=%0d required 0 0000 0 0",
                  out_valid, out_data, out_sat, out_count);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_beat(16'h0100, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0100 || out_count !== 8'd1) begin
         errors++;
         $display("FAIL reset_mid_result: valid=%0b data=%h count=%0d required 1 0100 1",
                  out_valid, out_data, out_count);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      in_data   = 16'h0000;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      test_reset;
      test_sum_count;
      test_saturation;
      test_zero_norm;
      test_backpressure;
      test_forced_close;
      test_reset_mid_group;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
